add_multiword_seq: RTL and testbench
====================================

Name: add_multiword_seq

Overview:
- Sequential wide adder that issues one 16-bit slice addition per clock.
- Computes a WORDS*16-bit sum by chaining the carry across slices, least-significant slice first.
- Sits directly upstream of, and wraps, the 16-bit fast adder slice. Its per-slice datapath is exactly Y16/Cout16 = A16 + B16 + Cin.
- Operands enter through a valid/ready handshake. The result leaves through a valid/ready handshake.

Parameters:
- WORDS, 4: number of 16-bit slices. Total operand width W = WORDS*16. Legal range 2..16.
- SLICE, 16: slice width. Fixed to 16; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands A, B, Cin present.
- in_ready  output  1  block can accept operands.
- A  input  W  operand A.
- B  input  W  operand B.
- Cin  input  1  carry into slice 0.
- out_valid  output  1  Y and Cout valid.
- out_ready  input  1  consumer accepts the result.
- Y  output  W  sum, modulo 2^W.
- Cout  output  1  carry out of the top slice.
- busy  output  1  high in RUN and DONE.

Behaviour:
- One clock domain. All state updates occur on the rising edge of clk.
- Reset: when rst_n=0 at an edge:
  - state goes to IDLE.
  - Y=0, Cout=0, out_valid=0, busy=0, in_ready=1 (in_ready is combinational from state).
  - Internal operand registers, carry and slice index are cleared.
  - Reset takes priority over every other event, including mid-RUN and DONE. An in-flight operation is discarded and no result is produced.
- States:
  - IDLE: in_ready=1, busy=0, out_valid=0. On an edge with in_valid=1:
    - latch A, B, Cin.
    - idx <= 0, carry <= Cin.
    - Y <= 0.
    - go to RUN.
  - RUN: in_ready=0, busy=1. Each edge computes {c, s} = A[idx*16 +: 16] + B[idx*16 +: 16] + carry (17-bit result), then:
    - Y[idx*16 +: 16] <= s.
    - carry <= c.
    - If idx == WORDS-1: Cout <= c, out_valid <= 1, go to DONE.
    - Otherwise: idx <= idx+1.
  - DONE: in_ready=0, busy=1, out_valid=1. Y and Cout are held stable. On an edge with out_ready=1:
    - out_valid <= 0, go to IDLE.
    - Y and Cout keep their last values until the next accept clears Y.
- Latency: out_valid rises exactly WORDS edges after the accepting edge (4 for the default).
- Minimum spacing between accepts is WORDS+2 edges when out_ready is held at 1.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; operands are not captured.
  - A, B and Cin may change freely after the accepting edge without affecting the result.
  - out_ready while out_valid=0 has no effect.
  - No combinational path from in_valid to out_valid, or from out_ready to in_ready. in_ready returns high only in IDLE, i.e. one edge after the result handshake.
- Arithmetic:
  - Unsigned. Y = (A + B + Cin) mod 2^W, Cout = bit W of the full sum.
  - Signed overflow is not reported.
  - Carry propagates through every slice, including the all-ones case, where carry ripples across all WORDS slices over WORDS cycles.
- Boundaries:
  - idx never exceeds WORDS-1.
  - Slices above the current idx in Y read 0 during RUN. Only the final value is guaranteed while out_valid=1.

Test Plan (WORDS=4, W=64):
- Zero add: A=0, B=0, Cin=0 → out_valid 4 edges after accept; Y=0, Cout=0. Repeat with Cin=1 → Y=0x0000000000000001, Cout=0.
- Full carry ripple: A=0xFFFFFFFFFFFFFFFF, B=0, Cin=1 → Y=0, Cout=1. A=B=0xFFFFFFFFFFFFFFFF, Cin=0 → Y=0xFFFFFFFFFFFFFFFE, Cout=1; same with Cin=1 → Y=0xFFFFFFFFFFFFFFFF, Cout=1.
- Slice-boundary carry: A=0x0000FFFF0000FFFF, B=0x0000000100000001, Cin=0 → Y=0x0001000000010000, Cout=0. A=0x0001, B=0x000E, Cin=1 → Y=0x0000000000000010.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → Y/Cout stable, in_ready=0. Drive in_valid=1 with new operands during RUN and DONE → ignored; result unchanged. Raise out_ready → out_valid falls next edge, in_ready=1.
- Back-to-back: out_ready=1 and in_valid=1 held continuously with 3 distinct operand pairs → 3 correct results, accepts spaced exactly 6 edges apart.
- Reset mid-operation: assert rst_n=0 for one edge at idx=2 → next cycle state IDLE, Y=0, Cout=0, out_valid=0, in_ready=1. No result is emitted for the aborted operation. A subsequent operation completes correctly.

Source files
------------

// File: rtl/add_multiword_seq_if.sv
// Operand/result handshake bundle for the sequential multi-word adder.
// The master drives operands and result acceptance; the slave is the adder.
interface add_multiword_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = WORDS * 16;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic         Cout;
  logic         busy;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Y, Cout, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Y, Cout, busy
  );
endinterface

// File: rtl/add_multiword_seq.sv
// Sequential WORDS*16-bit adder: one 16-bit slice addition per clock,
// least-significant slice first, with the carry chained between slices.
module add_multiword_seq #(
  parameter int WORDS = 4,
  parameter int SLICE = 16
) (
  input logic               clk,
  input logic               rst_n,
  add_multiword_seq_if.slave bus
);
  localparam int W  = WORDS * SLICE;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  if (SLICE != 16 || WORDS < 2 || WORDS > 16) begin : g_bad_param
    $error("add_multiword_seq: SLICE must be 16 and WORDS within 2..16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  y_q;
  logic          cout_q;
  logic          out_valid_q;

  int            base;
  logic [SLICE:0] slice_sum;

  // One 16-bit slice of the wide add, selected by the running slice index.
  always_comb begin
    base      = int'(idx_q) * SLICE;
    slice_sum = {1'b0, a_q[base +: SLICE]} + {1'b0, b_q[base +: SLICE]}
              + {{SLICE{1'b0}}, carry_q};
  end

  // NOTE: state is updated with non-blocking assignments only, and reset is
  // synchronous, so an abort at any point simply lands in IDLE on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.Cin;
            idx_q   <= '0;
            y_q     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          y_q[base +: SLICE] <= slice_sum[SLICE-1:0];
          carry_q            <= slice_sum[SLICE];
          if (idx_q == LAST) begin
            cout_q      <= slice_sum[SLICE];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          // Y and Cout stay put; only the next accept clears Y.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.Y         = y_q;
  assign bus.Cout      = cout_q;
endmodule

// File: tb/tb_add_multiword_seq.sv
// Scoreboard bench for add_multiword_seq (WORDS=4): expected sums are queued
// at each accept and compared when the result handshake completes.
module tb_add_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];

  add_multiword_seq_if #(.WORDS(WORDS)) bus ();

  add_multiword_seq #(.WORDS(WORDS), .SLICE(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: pops the oldest expectation on every completed handshake.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got Y=%h Cout=%b with nothing expected", bus.Y, bus.Cout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.Cout, bus.Y} !== {e.cout, e.y}) begin
          failures++;
          $display("FAIL result: got Y=%h Cout=%b, expected Y=%h Cout=%b", bus.Y, bus.Cout, e.y, e.cout);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents operands for exactly the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W-1:0] ey, input logic ec);
    int n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, n);
    end
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    e.y = ey;
    e.cout = ec;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    step();
    step();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.Cout} !== 4'b1000 || bus.Y !== '0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b Cout=%b Y=%h, expected 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.Cout, bus.Y);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero();
    int n;
    send(64'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_flags: busy=%b in_ready=%b, expected 1 0", bus.busy, bus.in_ready);
    end
    wait_valid(n);
    checks++;
    if (n != WORDS) begin
      failures++;
      $display("FAIL latency: out_valid after %0d edges, expected %0d", n, WORDS);
    end
    drain();
    send(64'h0, 64'h0, 1'b1, 64'h1, 1'b0);
    drain();
  endtask

  task automatic test_ripple();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();
  endtask

  task automatic test_boundary();
    send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0);
    send(64'h1, 64'hE, 1'b1, 64'h10, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
    bus.in_valid = 1'b1;
    bus.A = 64'h5555_5555_5555_5555;
    bus.B = 64'hAAAA_AAAA_AAAA_AAAA;
    bus.Cin = 1'b1;
    wait_valid(n);
    checks++;
    if (n != WORDS) begin
      failures++;
      $display("FAIL bp_latency: out_valid after %0d edges, expected %0d", n, WORDS);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.Y !== 64'h0000_0001_0000_0000 || bus.Cout !== 1'b0 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: Y=%h Cout=%b out_valid=%b in_ready=%b, expected 0000000100000000 0 1 0",
                 i, bus.Y, bus.Cout, bus.out_valid, bus.in_ready);
      end
      bus.A = bus.A + 64'h3;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bp_result_pending: %0d outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[3];
    logic [W-1:0] ob[3];
    logic         oc[3];
    logic [W-1:0] ey[3];
    logic         ec[3];
    int           acc_cyc[3];
    int           k;
    int           n;
    logic         was_ready;
    exp_t         e;
    oa[0] = 64'h0123_4567_89AB_CDEF; ob[0] = 64'h1111_1111_1111_1111; oc[0] = 1'b0;
    ey[0] = 64'h1234_5678_9ABC_DF00; ec[0] = 1'b0;
    oa[1] = 64'h8000_0000_0000_0000; ob[1] = 64'h8000_0000_0000_0000; oc[1] = 1'b1;
    ey[1] = 64'h0000_0000_0000_0001; ec[1] = 1'b1;
    oa[2] = 64'hDEAD_BEEF_0000_0000; ob[2] = 64'h0000_0000_1234_5678; oc[2] = 1'b0;
    ey[2] = 64'hDEAD_BEEF_1234_5678; ec[2] = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.A = oa[0];
    bus.B = ob[0];
    bus.Cin = oc[0];
    k = 0;
    n = 0;
    while (k < 3 && n < 60) begin
      was_ready = bus.in_ready;
      step();
      n++;
      if (was_ready) begin
        e.y = ey[k];
        e.cout = ec[k];
        sb.push_back(e);
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) begin
          bus.A = oa[k];
          bus.B = ob[k];
          bus.Cin = oc[k];
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (k != 3) begin
      failures++;
      $display("FAIL b2b_accepts: %0d accepts, expected 3", k);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != WORDS + 2) begin
          failures++;
          $display("FAIL b2b_spacing[%0d]: %0d edges, expected %0d", i, acc_cyc[i] - acc_cyc[i-1], WORDS + 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    bus.out_ready = 1'b1;
    send(64'h1234_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h1234_0000_0001_0000, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(sb.pop_back());
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.Cout} !== 4'b1000 || bus.Y !== '0) begin
      failures++;
      $display("FAIL mid_reset_state: in_ready=%b out_valid=%b busy=%b Cout=%b Y=%h, expected 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.Cout, bus.Y);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen_valid = 1'b1;
      step();
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_result: out_valid seen=%b, expected 0", seen_valid);
    end
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    drain();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    test_reset();
    test_zero();
    test_ripple();
    test_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
